// File: rtl/stream_arb_mux.sv
// N-to-1 valid/ready stream multiplexer with packet-locked arbitration
// (round-robin or fixed priority) and a single registered output stage.
module stream_arb_mux #(
   parameter int unsigned ELEM_WIDTH = 8,
   parameter int unsigned NUM_ELEM   = 6,
   parameter bit          RR_EN      = 1'b1,
   localparam int unsigned SEL_W     = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 arst_i,
   input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  data_i,
   input  logic [NUM_ELEM-1:0]                  valid_i,
   input  logic [NUM_ELEM-1:0]                  last_i,
   output logic [NUM_ELEM-1:0]                  ready_o,
   output logic [ELEM_WIDTH-1:0]                data_o,
   output logic                                 last_o,
   output logic                                 valid_o,
   input  logic                                 ready_i,
   output logic [SEL_W-1:0]                     sel_o,
   output logic                                 locked_o
);

   typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

   lock_state_t            state_q, state_d;
   logic                   valid_q, valid_d;
   logic                   last_q, last_d;
   logic [ELEM_WIDTH-1:0]  data_q, data_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [SEL_W-1:0]       ptr_q, ptr_d;

   logic                   ld;
   logic                   gnt_vld;
   logic [SEL_W-1:0]       gnt_idx;
   logic                   xfer;
   logic [31:0]            cand;

   assign ld = !valid_q || ready_i;

   // While locked, sel_q still names the locked channel: only it can load.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (state_q == ST_LOCKED) begin
         gnt_vld = 1'b1;
         gnt_idx = sel_q;
      end else if (RR_EN) begin
         for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_ELEM) cand = cand - NUM_ELEM;
            if (!gnt_vld && valid_i[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = SEL_W'(cand);
            end
         end
      end else begin
         for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            if (!gnt_vld && valid_i[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = SEL_W'(i);
            end
         end
      end
   end

   always_comb begin
      ready_o = '0;
      for (int unsigned k = 0; k < NUM_ELEM; k++) begin
         ready_o[k] = !arst_i && ld && gnt_vld && (gnt_idx == SEL_W'(k));
      end
   end

   assign xfer = ld && gnt_vld && valid_i[gnt_idx];

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         valid_d = 1'b1;
         data_d  = data_i[gnt_idx];
         last_d  = last_i[gnt_idx];
         sel_d   = gnt_idx;
         state_d = last_i[gnt_idx] ? ST_OPEN : ST_LOCKED;
         if (RR_EN && last_i[gnt_idx]) begin
            ptr_d = (gnt_idx == SEL_W'(NUM_ELEM - 1)) ? '0 : gnt_idx + SEL_W'(1);
         end
      end else if (ld) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= ST_OPEN;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   assign valid_o  = valid_q;
   assign data_o   = data_q;
   assign last_o   = last_q;
   assign sel_o    = sel_q;
   assign locked_o = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: behavioural arbitration model feeding a scoreboard
// of expected output beats, plus a fixed-priority instance on the same inputs.
module tb_stream_arb_mux;

   logic            clk = 1'b0;
   logic            arst_i = 1'b0;
   logic [5:0][7:0] data_i = '0;
   logic [5:0]      valid_i = '0;
   logic [5:0]      last_i = '0;
   logic            ready_i = 1'b1;

   logic [5:0] rr_ready_o, fp_ready_o;
   logic [7:0] rr_data_o, fp_data_o;
   logic       rr_last_o, fp_last_o, rr_valid_o, fp_valid_o;
   logic [2:0] rr_sel_o, fp_sel_o;
   logic       rr_locked_o, fp_locked_o;

   always #5 clk = ~clk;

   stream_arb_mux #(.ELEM_WIDTH(8), .NUM_ELEM(6), .RR_EN(1'b1)) dut (
      .clk_i(clk), .arst_i(arst_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
      .ready_o(rr_ready_o), .data_o(rr_data_o), .last_o(rr_last_o), .valid_o(rr_valid_o),
      .ready_i(ready_i), .sel_o(rr_sel_o), .locked_o(rr_locked_o));

   stream_arb_mux #(.ELEM_WIDTH(8), .NUM_ELEM(6), .RR_EN(1'b0)) dut_fp (
      .clk_i(clk), .arst_i(arst_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
      .ready_o(fp_ready_o), .data_o(fp_data_o), .last_o(fp_last_o), .valid_o(fp_valid_o),
      .ready_i(ready_i), .sel_o(fp_sel_o), .locked_o(fp_locked_o));

   int n_chk = 0;
   int n_bad = 0;

   // Per-channel source queues {last, data}; scoreboard entries {sel, last, data}.
   logic [8:0]  src_q [6][$];
   logic [11:0] sb_q[$];
   int          obs_sel[$];
   logic [5:0]  src_en = '1;
   int          n_in = 0, n_out = 0;
   logic        fp_chk = 1'b0;
   int          fp_cyc = 0;

   logic m_valid = 1'b0, m_locked = 1'b0;
   int   m_lock_ch = 0, m_ptr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic put(input int ch, input logic [7:0] d, input logic l);
      src_q[ch].push_back({l, d});
      n_in++;
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < 6; k++) begin
         valid_i[k] = src_en[k] && (src_q[k].size() > 0);
         data_i[k]  = (src_q[k].size() > 0) ? src_q[k][0][7:0] : 8'h00;
         last_i[k]  = (src_q[k].size() > 0) ? src_q[k][0][8] : 1'b0;
      end
   endtask

   task automatic cycle();
      logic       ld, gv, xfer;
      int         g;
      logic [5:0] exp_rdy;
      logic [11:0] e;
      drive_inputs();
      #1;
      ld = !m_valid || ready_i;
      gv = 1'b0;
      g  = 0;
      if (m_locked) begin
         gv = 1'b1;
         g  = m_lock_ch;
      end else begin
         for (int i = 0; i < 6; i++) begin
            int c;
            c = (m_ptr + i) % 6;
            if (!gv && valid_i[c]) begin
               gv = 1'b1;
               g  = c;
            end
         end
      end
      exp_rdy = (ld && gv) ? 6'(1 << g) : 6'b0;
      xfer = ld && gv && valid_i[g];
      chk("ready_o", rr_ready_o, exp_rdy);
      chk("valid_o", rr_valid_o, m_valid);
      chk("locked_o", rr_locked_o, m_locked);
      if (m_valid) begin
         if (sb_q.size() == 0) begin
            chk("sb_depth", sb_q.size(), 1);
         end else begin
            e = sb_q[0];
            chk("data_o", rr_data_o, e[7:0]);
            chk("last_o", rr_last_o, e[8]);
            chk("sel_o", rr_sel_o, e[11:9]);
            if (ready_i) begin
               obs_sel.push_back(int'(e[11:9]));
               void'(sb_q.pop_front());
               n_out++;
            end
         end
      end
      if (fp_chk) begin
         chk("fp_ready", fp_ready_o, 6'b001000);
         if (fp_cyc > 0) begin
            chk("fp_sel", fp_sel_o, 3);
            chk("fp_valid", fp_valid_o, 1);
         end
         fp_cyc++;
      end
      if (xfer) begin
         sb_q.push_back({3'(g), last_i[g], data_i[g]});
         void'(src_q[g].pop_front());
      end
      @(posedge clk);
      if (xfer) begin
         m_valid   = 1'b1;
         m_locked  = !last_i[g];
         m_lock_ch = g;
         if (last_i[g]) m_ptr = (g + 1) % 6;
      end else if (ld) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic run_drain(input int budget);
      logic busy;
      busy = 1'b1;
      for (int n = 0; n < budget && busy; n++) begin
         cycle();
         busy = m_valid;
         for (int k = 0; k < 6; k++) if (src_q[k].size() > 0) busy = 1'b1;
      end
      chk("drain", busy, 0);
      chk("beat_count", n_out, n_in);
   endtask

   task automatic chk_order(input string tag, input int exp[$]);
      chk({tag, "_len"}, obs_sel.size(), exp.size());
      for (int i = 0; i < exp.size() && i < obs_sel.size(); i++) chk(tag, obs_sel[i], exp[i]);
   endtask

   // Asserted mid-cycle so the checks below see the asynchronous effect.
   task automatic do_reset();
      #2;
      arst_i  = 1'b1;
      valid_i = '1;
      #1;
      chk("rst_valid", rr_valid_o, 0);
      chk("rst_locked", rr_locked_o, 0);
      chk("rst_sel", rr_sel_o, 0);
      chk("rst_data", rr_data_o, 0);
      chk("rst_last", rr_last_o, 0);
      chk("rst_ready", rr_ready_o, 0);
      chk("rst_fp_ready", fp_ready_o, 0);
      chk("rst_fp_valid", fp_valid_o, 0);
      for (int k = 0; k < 6; k++) src_q[k].delete();
      sb_q.delete();
      obs_sel.delete();
      n_in = 0; n_out = 0;
      m_valid = 1'b0; m_locked = 1'b0; m_lock_ch = 0; m_ptr = 0;
      src_en  = '1;
      ready_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      arst_i  = 1'b0;
      valid_i = '0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // single beat on channel 2
      put(2, 8'hA5, 1'b1);
      cycle();
      chk("t1_data", rr_data_o, 8'hA5);
      chk("t1_sel", rr_sel_o, 2);
      chk("t1_valid", rr_valid_o, 1);
      chk("t1_locked", rr_locked_o, 0);
      run_drain(10);

      // round-robin rotation over all channels
      do_reset();
      for (int k = 0; k < 6; k++) put(k, 8'h10 + 8'(k), 1'b1);
      put(0, 8'h60, 1'b1);
      run_drain(20);
      chk_order("t2_order", '{0, 1, 2, 3, 4, 5, 0});

      // 3-beat packet on channel 1 holds off channel 0
      do_reset();
      src_en = 6'b000010;
      put(1, 8'h11, 1'b0); put(1, 8'h12, 1'b0); put(1, 8'h13, 1'b1);
      for (int i = 0; i < 3; i++) put(0, 8'h20 + 8'(i), 1'b1);
      cycle();
      src_en = '1;
      run_drain(20);
      chk_order("t3_order", '{1, 1, 1, 0, 0, 0});

      // downstream stall holding 8'h3C
      do_reset();
      put(4, 8'h3C, 1'b1);
      cycle();
      put(5, 8'h51, 1'b1); put(5, 8'h52, 1'b1);
      ready_i = 1'b0;
      repeat (4) cycle();
      chk("t4_hold_data", rr_data_o, 8'h3C);
      chk("t4_hold_ready", rr_ready_o, 0);
      ready_i = 1'b1;
      run_drain(20);
      chk_order("t4_order", '{4, 5, 5});

      // fixed priority: channel 3 always beats channel 5
      do_reset();
      for (int i = 0; i < 10; i++) begin
         put(3, 8'h30 + 8'(i), 1'b1);
         put(5, 8'h50 + 8'(i), 1'b1);
      end
      fp_chk = 1'b1;
      fp_cyc = 0;
      repeat (8) cycle();
      fp_chk = 1'b0;
      run_drain(40);

      // asynchronous reset in the middle of a locked packet
      do_reset();
      for (int i = 0; i < 4; i++) put(2, 8'h70 + 8'(i), (i == 3));
      cycle();
      cycle();
      chk("t6_pre_lock", rr_locked_o, 1);
      chk("t6_pre_data", rr_data_o, 8'h71);
      do_reset();
      put(0, 8'h80, 1'b1);
      put(2, 8'h82, 1'b1);
      run_drain(10);
      chk_order("t6_order", '{0, 2});

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
